// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer run sequencer.
package fc_pkg;

    localparam int unsigned ERR_W = 2;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
    localparam logic [ERR_W-1:0] ERR_CTRL = 2'd1;
    localparam logic [ERR_W-1:0] ERR_CIM  = 2'd2;
    localparam logic [ERR_W-1:0] ERR_FUNC = 2'd3;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_LD_ACK,
        FR_LD_RUN,
        FR_CIM_WAIT,
        FR_CM_ACK,
        FR_CM_RUN,
        FR_HALT
    } front_state_e;

    typedef enum logic [2:0] {
        BK_IDLE,
        BK_FN_WAIT,
        BK_FN_ACK,
        BK_FN_RUN,
        BK_HALT
    } back_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_ACK,
        HS_RUN
    } hs_state_e;

endpackage

// File: rtl/fc_layer_seq_if.sv
// Handshake bundle between the sequencer, the previous/next layer and the fc stages.
interface fc_layer_seq_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    import fc_pkg::*;

    logic                 i_req;
    logic                 o_ack;
    logic                 o_start;
    logic                 i_ctrl_busy;
    logic                 o_cim_start;
    logic                 i_cim_busy;
    logic                 o_func_start;
    logic                 i_func_busy;
    logic                 i_next_busy;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic [ERR_W-1:0]     o_err_code;
    logic [CNT_WIDTH-1:0] o_run_count;

    // Environment side: previous layer, stages and next layer.
    modport master (
        output i_req, i_ctrl_busy, i_cim_busy, i_func_busy, i_next_busy,
        input  o_ack, o_start, o_cim_start, o_func_start,
        input  o_busy, o_done, o_error, o_err_code, o_run_count
    );

    // Sequencer side.
    modport slave (
        input  i_req, i_ctrl_busy, i_cim_busy, i_func_busy, i_next_busy,
        output o_ack, o_start, o_cim_start, o_func_start,
        output o_busy, o_done, o_error, o_err_code, o_run_count
    );

endinterface

// File: rtl/fc_hs_stage.sv
// Pulse-start / busy-ack tracker: flags the busy rise, the busy fall and an ack timeout.
module fc_hs_stage
    import fc_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic ack_c,
    output logic done_c,
    output logic timeout_c
);

    localparam int unsigned TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // busy is sampled in the ACK_TIMEOUT-1 cycles after the pulse; the error
    // register then shows the timeout exactly ACK_TIMEOUT cycles after the pulse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 2);

    hs_state_e        state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_c     = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        unique case (state_q)
            HS_IDLE: begin
                if (start) begin
                    state_d = HS_ACK;
                    cnt_d   = '0;
                end
            end
            HS_ACK: begin
                if (busy) begin
                    ack_c   = 1'b1;
                    state_d = HS_RUN;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = HS_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HS_RUN: begin
                if (!busy) begin
                    done_c  = 1'b1;
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Run-level sequencer for one fc layer: load -> CIM compute (front FSM), func (back FSM),
// linked by a one-deep token that marks a CIM result waiting for the func stage.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int unsigned OVERLAP     = 1,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rst,
    fc_layer_seq_if.slave  bus
);

    localparam bit OVL = (OVERLAP != 0);

    front_state_e         front_q, front_d;
    back_state_e          back_q, back_d;
    logic                 token_q, token_d;
    logic                 ack_q, ack_d;
    logic                 start_q, start_d;
    logic                 cim_start_q, cim_start_d;
    logic                 func_start_q, func_start_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic [ERR_W-1:0]     err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0] run_count_q, run_count_d;

    logic token_set, token_clr, accept_ok, any_tmo;
    logic ctrl_ack, ctrl_done, ctrl_tmo;
    logic cim_ack, cim_done, cim_tmo;
    logic func_ack, func_done, func_tmo;

    fc_hs_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start_q),
        .busy      (bus.i_ctrl_busy),
        .ack_c     (ctrl_ack),
        .done_c    (ctrl_done),
        .timeout_c (ctrl_tmo)
    );

    fc_hs_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs_cim (
        .clk       (clk),
        .rst       (rst),
        .start     (cim_start_q),
        .busy      (bus.i_cim_busy),
        .ack_c     (cim_ack),
        .done_c    (cim_done),
        .timeout_c (cim_tmo)
    );

    fc_hs_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs_func (
        .clk       (clk),
        .rst       (rst),
        .start     (func_start_q),
        .busy      (bus.i_func_busy),
        .ack_c     (func_ack),
        .done_c    (func_done),
        .timeout_c (func_tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q      <= FR_IDLE;
            back_q       <= BK_IDLE;
            token_q      <= 1'b0;
            ack_q        <= 1'b0;
            start_q      <= 1'b0;
            cim_start_q  <= 1'b0;
            func_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            run_count_q  <= '0;
        end else begin
            front_q      <= front_d;
            back_q       <= back_d;
            token_q      <= token_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            cim_start_q  <= cim_start_d;
            func_start_q <= func_start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            run_count_q  <= run_count_d;
        end
    end

    assign any_tmo = ctrl_tmo | cim_tmo | func_tmo;

    // Serial mode only admits a new input once the previous result is fully consumed.
    assign accept_ok = !error_q && !any_tmo &&
                       (OVL || ((back_q == BK_IDLE) && !token_q));

    // Front FSM: input load then CIM compute.
    always_comb begin
        front_d     = front_q;
        ack_d       = 1'b0;
        start_d     = 1'b0;
        cim_start_d = 1'b0;
        token_set   = 1'b0;
        unique case (front_q)
            FR_IDLE: begin
                if (bus.i_req && accept_ok) begin
                    ack_d   = 1'b1;
                    start_d = 1'b1;
                    front_d = FR_LD_ACK;
                end
            end
            FR_LD_ACK: begin
                if (ctrl_tmo)      front_d = FR_HALT;
                else if (ctrl_ack) front_d = FR_LD_RUN;
            end
            FR_LD_RUN: begin
                if (ctrl_done) front_d = FR_CIM_WAIT;
            end
            FR_CIM_WAIT: begin
                // CIM output buffer is free only once func has taken it.
                if (!token_q && (back_q == BK_IDLE)) begin
                    cim_start_d = 1'b1;
                    front_d     = FR_CM_ACK;
                end
            end
            FR_CM_ACK: begin
                if (cim_tmo)      front_d = FR_HALT;
                else if (cim_ack) front_d = FR_CM_RUN;
            end
            FR_CM_RUN: begin
                if (cim_done) begin
                    token_set = 1'b1;
                    front_d   = FR_IDLE;
                end
            end
            FR_HALT: front_d = FR_HALT;
            default: front_d = FR_IDLE;
        endcase
    end

    // Back FSM: func stage, gated by next-layer back-pressure.
    always_comb begin
        back_d       = back_q;
        func_start_d = 1'b0;
        done_d       = 1'b0;
        token_clr    = 1'b0;
        run_count_d  = run_count_q;
        unique case (back_q)
            BK_IDLE: begin
                if (token_q) back_d = BK_FN_WAIT;
            end
            BK_FN_WAIT: begin
                if (!bus.i_next_busy) begin
                    func_start_d = 1'b1;
                    token_clr    = 1'b1;
                    back_d       = BK_FN_ACK;
                end
            end
            BK_FN_ACK: begin
                if (func_tmo)      back_d = BK_HALT;
                else if (func_ack) back_d = BK_FN_RUN;
            end
            BK_FN_RUN: begin
                if (func_done) begin
                    done_d      = 1'b1;
                    run_count_d = run_count_q + CNT_WIDTH'(1);
                    back_d      = BK_IDLE;
                end
            end
            BK_HALT: back_d = BK_HALT;
            default: back_d = BK_IDLE;
        endcase
    end

    // Token, sticky error and busy summary.
    always_comb begin
        token_d = token_q;
        if (token_set)      token_d = 1'b1;
        else if (token_clr) token_d = 1'b0;

        error_d    = error_q | any_tmo;
        err_code_d = err_code_q;
        if (err_code_q == ERR_NONE) begin
            if (ctrl_tmo)      err_code_d = ERR_CTRL;
            else if (cim_tmo)  err_code_d = ERR_CIM;
            else if (func_tmo) err_code_d = ERR_FUNC;
        end

        busy_d = (front_d != FR_IDLE) || (back_d != BK_IDLE) || token_d;
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_start      = start_q;
    assign bus.o_cim_start  = cim_start_q;
    assign bus.o_func_start = func_start_q;
    assign bus.o_done       = done_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_error      = error_q;
    assign bus.o_err_code   = err_code_q;
    assign bus.o_run_count  = run_count_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench: a serial sequencer (OVERLAP=0) and an overlapped one with a 2-bit counter.
module tb_fc_layer_seq;

    localparam int ACK_TO = 16;
    localparam int NEV    = 5;   // 0 ack, 1 start, 2 cim_start, 3 func_start, 4 done

    logic clk = 1'b0;
    logic rst_s, rst_o;
    logic mon_clr;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    fc_layer_seq_if #(.CNT_WIDTH(16)) if_s ();
    fc_layer_seq_if #(.CNT_WIDTH(2))  if_o ();

    fc_layer_seq #(.OVERLAP(0), .ACK_TIMEOUT(ACK_TO), .CNT_WIDTH(16)) u_ser (
        .clk (clk),
        .rst (rst_s),
        .bus (if_s)
    );

    fc_layer_seq #(.OVERLAP(1), .ACK_TIMEOUT(ACK_TO), .CNT_WIDTH(2)) u_ovl (
        .clk (clk),
        .rst (rst_o),
        .bus (if_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage responders: 0..2 serial ctrl/cim/func, 3..5 overlapped ctrl/cim/func.
    logic start_v [6];
    int   ack_dly [6];
    int   run_len [6];
    logic hang    [6];

    assign start_v[0] = if_s.o_start;
    assign start_v[1] = if_s.o_cim_start;
    assign start_v[2] = if_s.o_func_start;
    assign start_v[3] = if_o.o_start;
    assign start_v[4] = if_o.o_cim_start;
    assign start_v[5] = if_o.o_func_start;

    for (genvar g = 0; g < 6; g++) begin : g_resp
        logic busy;
        initial begin
            busy = 1'b0;
            forever begin
                @(negedge clk);
                if (start_v[g] === 1'b1 && !hang[g]) begin
                    repeat (ack_dly[g]) @(posedge clk);
                    #1 busy = 1'b1;
                    repeat (run_len[g]) @(posedge clk);
                    #1 busy = 1'b0;
                end
            end
        end
    end

    assign if_s.i_ctrl_busy = g_resp[0].busy;
    assign if_s.i_cim_busy  = g_resp[1].busy;
    assign if_s.i_func_busy = g_resp[2].busy;
    assign if_o.i_ctrl_busy = g_resp[3].busy;
    assign if_o.i_cim_busy  = g_resp[4].busy;
    assign if_o.i_func_busy = g_resp[5].busy;

    // Pulse monitor: counts high cycles and stamps the first four occurrences.
    logic ev   [2][NEV];
    int   n_ev [2][NEV];
    int   t_ev [2][NEV][4];

    assign ev[0][0] = if_s.o_ack;
    assign ev[0][1] = if_s.o_start;
    assign ev[0][2] = if_s.o_cim_start;
    assign ev[0][3] = if_s.o_func_start;
    assign ev[0][4] = if_s.o_done;
    assign ev[1][0] = if_o.o_ack;
    assign ev[1][1] = if_o.o_start;
    assign ev[1][2] = if_o.o_cim_start;
    assign ev[1][3] = if_o.o_func_start;
    assign ev[1][4] = if_o.o_done;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < NEV; e++) begin
                if (mon_clr) begin
                    n_ev[d][e] = 0;
                end else if (ev[d][e] === 1'b1) begin
                    if (n_ev[d][e] < 4) t_ev[d][e][n_ev[d][e]] = cyc;
                    n_ev[d][e] = n_ev[d][e] + 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ev(input int d, input int e, input int cnt, input int budget,
                           input string tag);
        int k;
        k = 0;
        while (n_ev[d][e] < cnt && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_ev[d][e] >= cnt), 32'd1);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_s = 1'b1;
        rst_o = 1'b1;
        mon_clr = 1'b0;
        if_s.i_req = 1'b0;
        if_s.i_next_busy = 1'b0;
        if_o.i_req = 1'b0;
        if_o.i_next_busy = 1'b0;
        for (int g = 0; g < 6; g++) begin
            ack_dly[g] = 2;
            run_len[g] = 5;
            hang[g]    = 1'b0;
        end
        tick(3);

        // Reset state
        check("rst_outs_s", 32'({if_s.o_ack, if_s.o_start, if_s.o_cim_start, if_s.o_func_start,
              if_s.o_done, if_s.o_busy, if_s.o_error, if_s.o_err_code}), 32'd0);
        check("rst_cnt_s", 32'(if_s.o_run_count), 32'd0);
        check("rst_outs_o", 32'({if_o.o_ack, if_o.o_start, if_o.o_cim_start, if_o.o_func_start,
              if_o.o_done, if_o.o_busy, if_o.o_error, if_o.o_err_code}), 32'd0);
        check("rst_cnt_o", 32'(if_o.o_run_count), 32'd0);
        rst_s = 1'b0;
        rst_o = 1'b0;
        tick(1);

        // Serial single inference
        clear_mon();
        t0 = cyc;
        if_s.i_req = 1'b1;
        tick(2);
        if_s.i_req = 1'b0;
        check("ser_busy_run", 32'(if_s.o_busy), 32'd1);
        wait_ev(0, 4, 1, 100, "ser_done_wait");
        check("ser_ack_t",   32'(t_ev[0][0][0]), 32'(t0 + 1));
        check("ser_start_t", 32'(t_ev[0][1][0]), 32'(t0 + 1));
        check("ser_cim_t",   32'(t_ev[0][2][0]), 32'(t0 + 10));
        check("ser_func_t",  32'(t_ev[0][3][0]), 32'(t0 + 20));
        check("ser_done_t",  32'(t_ev[0][4][0]), 32'(t0 + 28));
        check("ser_ack_n",   32'(n_ev[0][0]), 32'd1);
        check("ser_done_n",  32'(n_ev[0][4]), 32'd1);
        check("ser_count",   32'(if_s.o_run_count), 32'd1);
        check("ser_idle",    32'(if_s.o_busy), 32'd0);

        // Serial, i_req held: second accept waits for the func stage to drain
        clear_mon();
        t0 = cyc;
        if_s.i_req = 1'b1;
        wait_ev(0, 0, 2, 100, "ser2_ack_wait");
        if_s.i_req = 1'b0;
        wait_ev(0, 4, 2, 100, "ser2_done_wait");
        check("ser2_ack2_t",  32'(t_ev[0][0][1]), 32'(t0 + 29));
        check("ser2_done2_t", 32'(t_ev[0][4][1]), 32'(t0 + 56));
        check("ser2_count",   32'(if_s.o_run_count), 32'd3);

        // Overlap: three inferences, long func stage
        run_len[5] = 20;
        clear_mon();
        t0 = cyc;
        if_o.i_req = 1'b1;
        wait_ev(1, 0, 3, 200, "ovl_ack_wait");
        if_o.i_req = 1'b0;
        wait_ev(1, 4, 3, 300, "ovl_done_wait");
        check("ovl_start2_t", 32'(t_ev[1][1][1]), 32'(t0 + 19));
        check("ovl_done1_t",  32'(t_ev[1][4][0]), 32'(t0 + 43));
        check("ovl_cim2_t",   32'(t_ev[1][2][1]), 32'(t0 + 44));
        check("ovl_ack3_t",   32'(t_ev[1][0][2]), 32'(t0 + 53));
        check("ovl_done3_t",  32'(t_ev[1][4][2]), 32'(t0 + 111));
        check("ovl_order",    32'(t_ev[1][1][1] < t_ev[1][4][0]), 32'd1);
        check("ovl_count",    32'(if_o.o_run_count), 32'd3);

        // Back-pressure: next layer busy until 30 cycles after token set; count wraps 5 -> 1
        run_len[5] = 5;
        clear_mon();
        t0 = cyc;
        if_o.i_next_busy = 1'b1;
        if_o.i_req = 1'b1;
        wait_ev(1, 0, 2, 100, "bp_ack_wait");
        if_o.i_req = 1'b0;
        tick(t0 + 47 - cyc);
        check("bp_no_func", 32'(n_ev[1][3]), 32'd0);
        check("bp_no_cim2", 32'(n_ev[1][2]), 32'd1);
        tick(1);
        if_o.i_next_busy = 1'b0;
        wait_ev(1, 4, 2, 100, "bp_done_wait");
        check("bp_func1_t", 32'(t_ev[1][3][0]), 32'(t0 + 49));
        check("bp_cim2_t",  32'(t_ev[1][2][1]), 32'(t0 + 58));
        check("bp_done2_t", 32'(t_ev[1][4][1]), 32'(t0 + 76));
        check("wrap_count", 32'(if_o.o_run_count), 32'd1);

        // Reset during CM_RUN, then a fresh request
        clear_mon();
        t0 = cyc;
        if_o.i_req = 1'b1;
        tick(2);
        if_o.i_req = 1'b0;
        tick(t0 + 14 - cyc);
        check("mid_busy", 32'(if_o.o_busy), 32'd1);
        rst_o = 1'b1;
        if_o.i_req = 1'b1;
        tick(1);
        rst_o = 1'b0;
        check("mid_rst_outs", 32'({if_o.o_ack, if_o.o_start, if_o.o_cim_start, if_o.o_func_start,
              if_o.o_done, if_o.o_busy, if_o.o_error, if_o.o_err_code}), 32'd0);
        check("mid_rst_cnt", 32'(if_o.o_run_count), 32'd0);
        tick(1);
        if_o.i_req = 1'b0;
        check("mid_ack_n", 32'(n_ev[1][0]), 32'd1);
        wait_ev(1, 4, 1, 100, "mid_done_wait");
        check("mid_ack2_t", 32'(t_ev[1][0][1]), 32'(t0 + 16));
        check("mid_done_t", 32'(t_ev[1][4][0]), 32'(t0 + 43));
        check("mid_count",  32'(if_o.o_run_count), 32'd1);

        // CIM never acknowledges: timeout, sticky error, no further accepts
        hang[1] = 1'b1;
        clear_mon();
        t0 = cyc;
        if_s.i_req = 1'b1;
        tick(2);
        if_s.i_req = 1'b0;
        tick(t0 + 25 - cyc);
        check("tmo_err_pre",  32'(if_s.o_error), 32'd0);
        check("tmo_code_pre", 32'(if_s.o_err_code), 32'd0);
        tick(1);
        check("tmo_err",   32'(if_s.o_error), 32'd1);
        check("tmo_code",  32'(if_s.o_err_code), 32'd2);
        check("tmo_cim_t", 32'(t_ev[0][2][0]), 32'(t0 + 10));
        if_s.i_req = 1'b1;
        tick(20);
        check("tmo_no_ack",  32'(n_ev[0][0]), 32'd1);
        check("tmo_sticky",  32'(if_s.o_error), 32'd1);
        check("tmo_busy",    32'(if_s.o_busy), 32'd1);
        if_s.i_req = 1'b0;
        rst_s = 1'b1;
        tick(1);
        rst_s = 1'b0;
        hang[1] = 1'b0;
        check("tmo_rst_err",  32'({if_s.o_error, if_s.o_err_code}), 32'd0);
        check("tmo_rst_cnt",  32'(if_s.o_run_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Run-level sequencer for one fully-connected layer.
- Per inference it issues, in order: an input-load start to the layer's ctrl, a compute start to the CIM tile array, and a start to the layer's activation/func stage. Each stage uses a pulse-start / busy-ack handshake.
- It sits between the previous layer's handoff (request/ack) and the fc layer plus its CIM tiles. Chaining multiple layers is just chaining these sequencers.
- Optionally overlaps the next inference's input load with the current func stage, giving a two-stage pipeline.

Parameters:
- OVERLAP, 1, 1 allows load of inference N+1 while func of N runs; 0 runs strictly serially.
- ACK_TIMEOUT, 16, max cycles from a start pulse to the rising edge of the corresponding busy before an error is raised.
- CNT_WIDTH, 16, width of the completed-inference counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  previous layer reports the input buffer is full; level, held until o_ack
- o_ack  out  1  one-cycle pulse: request accepted, input buffer may be reused after load completes
- o_start  out  1  one-cycle pulse to fc ctrl (input load into CIM input regs)
- i_ctrl_busy  in  1  fc ctrl busy
- o_cim_start  out  1  one-cycle pulse to CIM tiles (compute)
- i_cim_busy  in  1  CIM busy
- o_func_start  out  1  one-cycle pulse to func stage
- i_func_busy  in  1  func stage busy
- i_next_busy  in  1  next layer busy; func must not start while high
- o_busy  out  1  any stage active or pending
- o_done  out  1  one-cycle pulse when a func stage completes
- o_error  out  1  sticky ack-timeout flag, cleared only by rst
- o_err_code  out  2  0 none, 1 ctrl, 2 cim, 3 func: first stage that timed out
- o_run_count  out  CNT_WIDTH  completed inferences, wraps modulo 2^CNT_WIDTH

Behaviour:
- All outputs are registered. Reset value of every output is 0; both FSMs go to IDLE, the token is cleared, and the counter is cleared.
- Reset mid-operation abandons the run immediately. No pulses are emitted in the reset cycle or the cycle after.
- Handshake rule for each stage, with the start pulse in cycle T:
  - busy is sampled from T+1.
  - Wait for busy=1 (ACK phase, timeout counter running), then wait for busy=0 (RUN phase, no timeout).
  - busy=1 already at T+1 counts as the ack.
  - busy still 0 after ACK_TIMEOUT cycles: set o_error, latch o_err_code if it is currently 0, and send the offending FSM to HALT. HALT is exited only by rst.
- Front FSM states: IDLE, LD_ACK, LD_RUN, CIM_WAIT, CM_ACK, CM_RUN, HALT.
  - IDLE: if i_req=1, pulse o_ack and o_start, go to LD_ACK.
  - LD_ACK -> LD_RUN on ctrl busy rise.
  - LD_RUN -> CIM_WAIT when i_ctrl_busy=0.
  - CIM_WAIT: if token=0 and back FSM is IDLE, pulse o_cim_start and go to CM_ACK. Otherwise hold, because the CIM output buffer is still being consumed.
  - CM_ACK -> CM_RUN on CIM busy rise.
  - CM_RUN -> IDLE when i_cim_busy=0, and set token=1.
- Back FSM states: IDLE, FN_WAIT, FN_ACK, FN_RUN, HALT.
  - IDLE -> FN_WAIT when token=1.
  - FN_WAIT: when i_next_busy=0, pulse o_func_start, clear token, go to FN_ACK.
  - FN_ACK -> FN_RUN on func busy rise.
  - FN_RUN: when i_func_busy=0, pulse o_done, increment o_run_count, go to IDLE.
- OVERLAP=1: the front FSM may accept i_req while the back FSM is in any non-IDLE state.
- OVERLAP=0: the front FSM accepts i_req only when the back FSM is IDLE and token=0.
- Simultaneous events:
  - Token set (CM_RUN exit) and back FSM sampling token in the same cycle: the back FSM sees the new token the next cycle, giving one bubble.
  - Token clear and a new set can never coincide, because CIM_WAIT is gated on back IDLE.
- Latency: i_req to o_start is 1 cycle (pulse in the cycle after i_req is sampled). CM_RUN exit to o_func_start is at least 2 cycles.
- o_busy = front not IDLE, or back not IDLE, or token=1.
- HALT in either FSM leaves the other FSM free to finish its current stage. No new i_req is accepted after an error.

Decomposition:
- Shared package fc_pkg holds:
  - the state enums for the front and back FSMs;
  - the err_code localparams (ERR_NONE, ERR_CTRL, ERR_CIM, ERR_FUNC).
- One natural sub-module: fc_hs_stage, a reusable pulse/ack/run handshake with timeout. Instantiated three times, it reports done and timeout to the FSMs.

Test Plan:
- Serial run, OVERLAP=0, with ctrl/cim/func busy each lasting 5 cycles after a 2-cycle ack delay:
  - one o_ack, then o_start, o_cim_start, o_func_start in order;
  - o_done once, o_run_count=1, o_busy back to 0.
- Overlap, OVERLAP=1, with i_req held high for 3 inferences and a func busy of 20 cycles:
  - the second o_start occurs before the first o_done;
  - the second o_cim_start is delayed until after the first o_done;
  - o_run_count=3 at the end.
- Back-pressure: i_next_busy=1 for 30 cycles after token set:
  - no o_func_start until 1 cycle after i_next_busy falls;
  - no second o_cim_start during that time.
- Timeout: i_cim_busy never rises after o_cim_start:
  - exactly ACK_TIMEOUT cycles later o_error=1 and o_err_code=2;
  - no further o_ack even with i_req=1.
- Reset mid-run: assert rst during CM_RUN:
  - next cycle all outputs are 0 and o_run_count=0;
  - a fresh i_req completes normally.
- Counter wrap: set CNT_WIDTH=2 and run 5 inferences -> o_run_count=1.
